// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared defaults, accumulator sizing and saturation helper for fir_bh
package fir_pkg;

  // Default datapath geometry
  localparam int DEF_DATA_W = 8;
  localparam int DEF_COEF_W = 8;
  localparam int DEF_TAPS   = 4;

  // h0 (newest sample) sits in the low slice: h0=1, h1=2, h2=3, h3=4
  localparam logic [DEF_TAPS*DEF_COEF_W-1:0] DEF_COEFFS = {8'd4, 8'd3, 8'd2, 8'd1};

  // Full-precision accumulator width for the default geometry
  localparam int ACC_W = DEF_DATA_W + DEF_COEF_W + $clog2(DEF_TAPS);

  // Clamp an unsigned accumulator to the largest dw-bit value.
  // Carried at 64 bits so any legal parameter set can share one helper.
  function automatic logic [63:0] saturate(input logic [63:0] acc, input int dw);
    logic [63:0] max_val;
    max_val = (64'd1 << dw) - 64'd1;
    return (acc > max_val) ? max_val : acc;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// rtl/fir_delay_line.sv - resettable sample shift register exposing every stage
module fir_delay_line #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         din,
  output logic [DEPTH*DATA_W-1:0]   stages
);

  logic [DEPTH*DATA_W-1:0] q;

  // Stage 0 takes the new sample, every later stage takes its predecessor
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q[DATA_W-1:0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        q[i*DATA_W +: DATA_W] <= q[(i-1)*DATA_W +: DATA_W];
      end
    end
  end

  assign stages = q;

endmodule

// File: rtl/fir_bh.sv
// rtl/fir_bh.sv - unsigned direct-form FIR with saturated registered output
module fir_bh
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int COEF_W = DEF_COEF_W,
  parameter logic [TAPS*COEF_W-1:0] COEFFS = DEF_COEFFS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y
);

  // Wide enough that summing TAPS full-scale products never wraps
  localparam int SUM_W = DATA_W + COEF_W + $clog2(TAPS);
  localparam int DEPTH = TAPS - 1;

  logic [DEPTH*DATA_W-1:0] d;
  logic [SUM_W-1:0]        acc;
  logic [DATA_W-1:0]       y_next;

  fir_delay_line #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_delay (
    .clk    (clk),
    .rst    (rst),
    .din    (x),
    .stages (d)
  );

  // Multiply-accumulate over the live sample and the pre-edge history
  always_comb begin
    acc = SUM_W'(COEFFS[COEF_W-1:0]) * SUM_W'(x);
    for (int i = 1; i < TAPS; i++) begin
      acc = acc + SUM_W'(COEFFS[i*COEF_W +: COEF_W]) * SUM_W'(d[(i-1)*DATA_W +: DATA_W]);
    end
  end

  assign y_next = DATA_W'(saturate(64'(acc), DATA_W));

  // Output register; cleared with the delay line so history restarts at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
    end else begin
      y <= y_next;
    end
  end

endmodule

// File: tb/tb_fir_bh.sv
// tb/tb_fir_bh.sv - scoreboard bench for fir_bh (default and 2-tap variants)
module tb_fir_bh;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x, x2;
  logic [7:0] y, y2;

  int total  = 0;
  int passed = 0;

  logic [7:0] sbq[$];
  logic [7:0] sbq2[$];

  always #5 clk = ~clk;

  fir_bh dut (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .y   (y)
  );

  fir_bh #(
    .TAPS   (2),
    .COEFFS (16'h0101)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .x   (x2),
    .y   (y2)
  );

  // Drive one edge on both DUTs, queue expectations, return 1 ns after the edge
  task automatic drive(input logic r, input logic [7:0] xv, input logic [7:0] e,
                       input logic [7:0] xv2, input logic [7:0] e2);
    @(negedge clk);
    rst = r;
    x   = xv;
    x2  = xv2;
    sbq.push_back(e);
    sbq2.push_back(e2);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e, e2;
    for (int i = 0; i < 5; i++) begin
      drive((i < 2), 8'd0, 8'd0, 8'd0, 8'd0);
      e  = sbq.pop_front();
      e2 = sbq2.pop_front();
      total++;
      if (y !== e) $display("FAIL reset[%0d]: y=%0d expected %0d", i, y, e);
      else passed++;
      total++;
      if (y2 !== e2) $display("FAIL reset_taps2[%0d]: y2=%0d expected %0d", i, y2, e2);
      else passed++;
    end
  endtask

  task automatic test_ramp();
    logic [7:0] exp_tab [8] = '{8'd1, 8'd4, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
    logic [7:0] e;
    drive(1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
    void'(sbq2.pop_front());
    e = sbq.pop_front();
    total++;
    if (y !== e) $display("FAIL ramp_reset: y=%0d expected %0d", y, e);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'(i + 1), exp_tab[i], 8'd0, 8'd0);
      void'(sbq2.pop_front());
      e = sbq.pop_front();
      total++;
      if (y !== e) $display("FAIL ramp[%0d]: y=%0d expected %0d", i, y, e);
      else passed++;
    end
  endtask

  task automatic test_impulse();
    logic [7:0] exp_tab [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0};
    logic [7:0] e;
    drive(1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
    void'(sbq.pop_front());
    void'(sbq2.pop_front());
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, (i == 0) ? 8'd1 : 8'd0, exp_tab[i], 8'd0, 8'd0);
      void'(sbq2.pop_front());
      e = sbq.pop_front();
      total++;
      if (y !== e) $display("FAIL impulse[%0d]: y=%0d expected %0d", i, y, e);
      else passed++;
    end
  endtask

  task automatic test_saturation();
    logic [7:0] e;
    drive(1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
    void'(sbq.pop_front());
    void'(sbq2.pop_front());
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'd255, 8'd255, 8'd255, 8'd255);
      e = sbq.pop_front();
      total++;
      if (y !== e) $display("FAIL saturation[%0d]: y=%0d expected %0d", i, y, e);
      else passed++;
      e = sbq2.pop_front();
      total++;
      if (y2 !== e) $display("FAIL saturation_taps2[%0d]: y2=%0d expected %0d", i, y2, e);
      else passed++;
    end
  endtask

  task automatic test_midstream_reset();
    logic [7:0] exp_tab [8] = '{8'd1, 8'd4, 8'd10, 8'd20, 8'd30, 8'd0, 8'd6, 8'd19};
    logic [7:0] xin     [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd9, 8'd6, 8'd7};
    logic [7:0] e;
    drive(1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
    void'(sbq.pop_front());
    void'(sbq2.pop_front());
    for (int i = 0; i < 8; i++) begin
      drive((i == 5), xin[i], exp_tab[i], 8'd0, 8'd0);
      void'(sbq2.pop_front());
      e = sbq.pop_front();
      total++;
      if (y !== e) $display("FAIL midstream[%0d]: y=%0d expected %0d", i, y, e);
      else passed++;
    end
  endtask

  task automatic test_taps2();
    logic [7:0] xin     [4] = '{8'd10, 8'd20, 8'd30, 8'd0};
    logic [7:0] exp_tab [4] = '{8'd10, 8'd30, 8'd50, 8'd30};
    logic [7:0] e;
    drive(1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
    void'(sbq.pop_front());
    void'(sbq2.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'd0, 8'd0, xin[i], exp_tab[i]);
      void'(sbq.pop_front());
      e = sbq2.pop_front();
      total++;
      if (y2 !== e) $display("FAIL taps2[%0d]: y2=%0d expected %0d", i, y2, e);
      else passed++;
    end
  endtask

  // Random stream against an independent behavioural model of both filters
  task automatic test_back_to_back();
    int          hist [3];
    int          prev2;
    int          acc, acc2;
    logic [7:0]  xv, xv2, e, e2;
    drive(1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
    void'(sbq.pop_front());
    void'(sbq2.pop_front());
    hist  = '{0, 0, 0};
    prev2 = 0;
    for (int i = 0; i < 40; i++) begin
      xv   = (i % 7 == 6) ? 8'($urandom_range(255)) : 8'($urandom_range(40));
      xv2  = 8'($urandom_range(160));
      acc  = 1 * int'(xv) + 2 * hist[0] + 3 * hist[1] + 4 * hist[2];
      acc2 = int'(xv2) + prev2;
      drive(1'b0, xv, (acc > 255) ? 8'd255 : 8'(acc), xv2, (acc2 > 255) ? 8'd255 : 8'(acc2));
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = int'(xv);
      prev2   = int'(xv2);
      e  = sbq.pop_front();
      e2 = sbq2.pop_front();
      total++;
      if (y !== e) $display("FAIL stream[%0d]: y=%0d expected %0d", i, y, e);
      else passed++;
      total++;
      if (y2 !== e2) $display("FAIL stream_taps2[%0d]: y2=%0d expected %0d", i, y2, e2);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1;
    x   = 8'd0;
    x2  = 8'd0;
    test_reset();
    test_ramp();
    test_impulse();
    test_saturation();
    test_midstream_reset();
    test_taps2();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
